vga_fb_write_arbiter: RTL and testbench

- Shares the single write port of the VGA pixel framebuffer between two pixel requesters: req0 (drawing engine) and req1 (switch/host writer).
- Contains a built-in clear-screen sequencer that fills the whole frame with one colour.
- Sits between the pixel producers and the framebuffer RAM. The vga_driver read side stays untouched.
- Pixel format is 8-bit RRRGGGBB. Coordinates are 9-bit x/y.

---
 rtl/vga_fb_pkg.sv | 12 +
 rtl/vga_fb_addr_calc.sv | 16 +
 rtl/vga_fb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_vga_fb_write_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA framebuffer write arbiter.
package vga_fb_pkg;
    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;
    localparam int COLOR_W   = 8;
    localparam int COORD_W   = 9;

    typedef enum logic {IDLE, CLEAR} state_t;

    // RRRGGGBB pixel
    typedef logic [COLOR_W-1:0] color_t;
endpackage

// File: rtl/vga_fb_addr_calc.sv
// Combinational pixel coordinate to linear framebuffer address, with range flag.
module vga_fb_addr_calc
    import vga_fb_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 17
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               out_of_range
);
    assign addr         = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    assign out_of_range = (x >= COORD_W'(H_RES)) || (y >= COORD_W'(V_RES));
endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port plus a full-frame clear sequencer.
// Optional build macro VGA_FB_BLANK_GATE_EN restricts writes to the blanking interval.
module vga_fb_write_arbiter #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [8:0]         req0_x,
    input  logic [8:0]         req0_y,
    input  logic [COLOR_W-1:0] req0_color,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [8:0]         req1_x,
    input  logic [8:0]         req1_y,
    input  logic [COLOR_W-1:0] req1_color,
    output logic               req1_ready,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    input  logic               in_blank,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               drop_pulse
);
    import vga_fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    state_t               state_reg;
    logic                 last_grant_reg;
    logic [ADDR_W-1:0]    count_reg;
    logic [COLOR_W-1:0]   clear_color_reg;

    logic                 gate;
    logic                 grant0;
    logic                 grant1;
    logic                 open;
    logic                 accept;
    logic [COORD_W-1:0]   sel_x;
    logic [COORD_W-1:0]   sel_y;
    logic [COLOR_W-1:0]   sel_color;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_oor;

`ifdef VGA_FB_BLANK_GATE_EN
    assign gate = in_blank;
`else
    logic unused_in_blank;
    assign unused_in_blank = in_blank;
    assign gate = 1'b1;
`endif

    // last_grant_reg==1 means req1 was served last, so req0 wins a tie
    assign grant0 = req0_valid & (~req1_valid | last_grant_reg);
    assign grant1 = req1_valid & ~grant0;
    assign open   = (state_reg == IDLE) & ~clear_start & gate;

    assign req0_ready = open & grant0;
    assign req1_ready = open & grant1;
    assign accept     = req0_ready | req1_ready;

    assign sel_x     = grant1 ? req1_x     : req0_x;
    assign sel_y     = grant1 ? req1_y     : req0_y;
    assign sel_color = grant1 ? req1_color : req0_color;

    vga_fb_addr_calc #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .x            (sel_x),
        .y            (sel_y),
        .addr         (sel_addr),
        .out_of_range (sel_oor)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            count_reg       <= '0;
            clear_color_reg <= '0;
            clear_busy      <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_data        <= '0;
            drop_pulse      <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            drop_pulse <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear_start) begin
                        state_reg       <= CLEAR;
                        clear_busy      <= 1'b1;
                        count_reg       <= '0;
                        clear_color_reg <= clear_color;
                    end else if (accept) begin
                        last_grant_reg <= grant1;
                        if (sel_oor) begin
                            drop_pulse <= 1'b1;
                        end else begin
                            mem_we   <= 1'b1;
                            mem_addr <= sel_addr;
                            mem_data <= sel_color;
                        end
                    end
                end
                CLEAR: begin
                    if (gate) begin
                        mem_we   <= 1'b1;
                        mem_addr <= count_reg;
                        mem_data <= clear_color_reg;
                        if (count_reg == LAST_ADDR) begin
                            state_reg  <= IDLE;
                            clear_busy <= 1'b0;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Directed self-checking bench for vga_fb_write_arbiter (default 320x240 frame).
module tb_vga_fb_write_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [8:0]  req0_x, req0_y, req1_x, req1_y;
    logic [7:0]  req0_color, req1_color;
    logic        req0_ready, req1_ready;
    logic        clear_start;
    logic [7:0]  clear_color;
    logic        clear_busy;
    logic        in_blank;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_data;
    logic        drop_pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    vga_fb_write_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_color  (req0_color),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_color  (req1_color),
        .req1_ready  (req1_ready),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .in_blank    (in_blank),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .drop_pulse  (drop_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        int  exp_addr, writes, busy_cyc, errs;
        bit  done;

        reset = 1'b0;
        req0_valid = 0; req0_x = 0; req0_y = 0; req0_color = 0;
        req1_valid = 0; req1_x = 0; req1_y = 0; req1_color = 0;
        clear_start = 0; clear_color = 0;
`ifdef VGA_FB_BLANK_GATE_EN
        in_blank = 1'b1;
`else
        in_blank = 1'b0;
`endif
        tick();
        tick();
        $display("txn reset");
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_drop", drop_pulse, 0);
        reset = 1'b1;
        #1;

        // single req0 write at (5,2): 2*320+5 = 645
        $display("txn req0 write x=5 y=2 color=e0");
        req0_valid = 1; req0_x = 5; req0_y = 2; req0_color = 8'hE0;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        check("single_we", mem_we, 1);
        check("single_addr", mem_addr, 645);
        check("single_data", mem_data, 8'hE0);
        tick();
        check("single_we_off", mem_we, 0);
        check("single_addr_hold", mem_addr, 645);

        // both valid after reset: grants 0,1,0,1; req0 -> 7, req1 -> 1*320+2 = 322
        do_reset();
        req0_valid = 1; req0_x = 7; req0_y = 0; req0_color = 8'h11;
        req1_valid = 1; req1_x = 2; req1_y = 1; req1_color = 8'h22;
        for (int i = 0; i < 4; i++) begin
            $display("txn round-robin cycle %0d", i);
            #1;
            check("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check("rr_we", mem_we, 1);
            check("rr_addr", mem_addr, (i % 2 == 0) ? 7 : 322);
            check("rr_data", mem_data, (i % 2 == 0) ? 8'h11 : 8'h22);
        end
        req0_valid = 0; req1_valid = 0;

        // out-of-range x=320 from req1
        $display("txn req1 out-of-range x=320 y=0");
        req1_valid = 1; req1_x = 320; req1_y = 0; req1_color = 8'h77;
        #1;
        check("oor_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        check("oor_we", mem_we, 0);
        check("oor_drop", drop_pulse, 1);
        tick();
        check("oor_drop_off", drop_pulse, 0);

        // clear with req0 pending
        $display("txn clear color=1c with req0 pending");
        req0_valid = 1; req0_x = 3; req0_y = 0; req0_color = 8'h55;
        clear_start = 1; clear_color = 8'h1C;
        #1;
        check("clr_ready0_blocked", req0_ready, 0);
        check("clr_ready1_blocked", req1_ready, 0);
        tick();
        clear_start = 0;
        exp_addr = 0; writes = 0; busy_cyc = 0; errs = 0; done = 0;
        for (int c = 0; c < 80000 && !done; c++) begin
            if (mem_we) begin
                if (mem_addr !== exp_addr[16:0] || mem_data !== 8'h1C) errs++;
                exp_addr++;
                writes++;
            end
            if (clear_busy) begin
                busy_cyc++;
                if (req0_ready) errs++;
                tick();
            end else begin
                done = 1;
            end
        end
        check("clr_finished", done, 1);
        check("clr_busy_cycles", busy_cyc, 76800);
        check("clr_writes", writes, 76800);
        check("clr_seq_errors", errs, 0);
        check("clr_post_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        check("clr_post_we", mem_we, 1);
        check("clr_post_addr", mem_addr, 3);
        check("clr_post_data", mem_data, 8'h55);

        // reset partway through a fill
        $display("txn reset at fill cycle 100");
        clear_start = 1; clear_color = 8'hAA;
        tick();
        clear_start = 0;
        repeat (100) tick();
        check("abort_busy_before", clear_busy, 1);
        reset = 0;
        req0_valid = 1; req0_x = 10; req0_y = 0; req0_color = 8'h3C;
        req1_valid = 1; req1_x = 20; req1_y = 0; req1_color = 8'hC3;
        tick();
        check("abort_we", mem_we, 0);
        check("abort_busy", clear_busy, 0);
        reset = 1;
        #1;
        check("abort_tie_ready0", req0_ready, 1);
        check("abort_tie_ready1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        check("abort_post_we", mem_we, 1);
        check("abort_post_addr", mem_addr, 10);
        check("abort_post_data", mem_data, 8'h3C);

`ifdef VGA_FB_BLANK_GATE_EN
        $display("txn blank-gated req0");
        in_blank = 0;
        req0_valid = 1; req0_x = 1; req0_y = 0; req0_color = 8'h33;
        #1;
        check("gate_ready0_low", req0_ready, 0);
        tick();
        check("gate_no_we", mem_we, 0);
        in_blank = 1;
        #1;
        check("gate_ready0_high", req0_ready, 1);
        tick();
        req0_valid = 0;
        check("gate_we", mem_we, 1);
        check("gate_addr", mem_addr, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
